mips_exec_alu: RTL and testbench
================================

Name: mips_exec_alu

Overview:
- Registered MIPS execute-stage arithmetic block combining three functions:
  - ALU-control decode (ALUOp/funct to 4-bit ALU operation code).
  - 32-bit main ALU with zero and overflow flags.
  - Branch-target adder (PC+4 plus sign-extended offset shifted left 2).
- Sits between the register-file/operand-B mux and the data-memory/PC-select logic of the single-cycle datapath.
- All outputs are captured in an output register, giving one-cycle latency.

Parameters:
- WIDTH, 32, datapath width of ALU operands, result and adder.
- CTRL_W, 4, width of the ALU operation code.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid this cycle; the output register loads only when 1.
- a  in  WIDTH  operand A (register read data 1).
- b  in  WIDTH  operand B (read data 2 or sign-extended immediate, already muxed).
- alu_op  in  2  ALUOp from main control.
- funct  in  6  instruction funct field.
- pc_plus4  in  WIDTH  PC+4 value.
- imm_ext  in  WIDTH  sign-extended 16-bit immediate (unshifted).
- out_valid  out  1  registered copy of in_valid.
- alu_ctrl  out  CTRL_W  registered ALU operation code.
- result  out  WIDTH  registered ALU result.
- zero  out  1  registered; 1 when the ALU result equals 0.
- ovf  out  1  registered signed overflow flag.
- branch_target  out  WIDTH  registered pc_plus4 + (imm_ext << 2).
- illegal  out  1  registered; 1 for an unsupported funct under alu_op=10.

Behaviour:
- Reset: while rst_n=0, all outputs are 0 immediately (async). Release is synchronous to clk. A reset asserted mid-operation discards the captured values.
- Latency: outputs reflect the inputs sampled at the previous rising edge with in_valid=1. When in_valid=0, result, zero, ovf, alu_ctrl, branch_target and illegal hold their values and out_valid drops to 0.
- ALU control decode (combinational, before the register):
  - alu_op 00 -> 0010 (add; lw/sw).
  - alu_op 01 -> 0110 (sub; beq).
  - alu_op 11 -> 0001 (or; ori).
  - alu_op 10 decodes funct:
    - 100000 add -> 0010.
    - 100010 sub -> 0110.
    - 100100 and -> 0000.
    - 100101 or -> 0001.
    - 101010 slt -> 0111.
    - 100111 nor -> 1100.
    - 100001 addu -> 0010 with ovf forced to 0.
    - 100011 subu -> 0110 with ovf forced to 0.
    - Any other funct -> 1111 with illegal=1.
  - funct is ignored unless alu_op=10.
- ALU operations:
  - 0000: a & b.
  - 0001: a | b.
  - 0010: a + b, modulo 2^32.
  - 0110: a - b, modulo 2^32.
  - 0111: result = 1 if a < b as signed (computed from the sub sign XOR sub overflow), else 0.
  - 1100: ~(a | b).
  - 1111 or any other code: result 0.
- zero = (result == 0). This includes the illegal case, where zero=1.
- ovf:
  - add: set when both operands have the same sign and the sum sign differs.
  - sub: set when the operand signs differ and the result sign differs from a.
  - All other operations, including addu/subu: 0.
- Overflow never suppresses the result or writeback; it is a flag only.
- branch_target = pc_plus4 + {imm_ext[WIDTH-3:0], 2'b00}, modulo 2^32. Wrap-around is silent and independent of alu_op.

Decomposition:
- Shared package mips_alu_pkg holds:
  - ALU op-code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_ILLEGAL).
  - ALUOp constants (ALUOP_ADD, ALUOP_SUB, ALUOP_RTYPE, ALUOP_OR).
  - Funct constants.
- One natural combinational sub-module: mips_alu_core (a, b, ctrl, no_ovf -> result, zero, ovf).
- ALU-control decode and the branch adder are inlined in the top module.

Test Plan:
- Reset: drive rst_n=0 asynchronously between edges -> all outputs 0 at once. Release, then in_valid=1, alu_op=00, a=5, b=7 -> after one edge: result=12, alu_ctrl=0010, zero=0, out_valid=1.
- R-type sweep, alu_op=10, a=0x0000000F, b=0x000000F0:
  - add -> 0xFF.
  - sub -> 0xFFFFFF1F.
  - and -> 0 with zero=1.
  - or -> 0xFF.
  - nor -> 0xFFFFFF00.
  - slt -> 1.
  - slt with a=0xFFFFFFFF, b=1 -> 1.
  - slt with a=1, b=0xFFFFFFFF -> 0.
- Overflow:
  - add 0x7FFFFFFF+1 -> result 0x80000000, ovf=1.
  - addu with the same operands -> ovf=0.
  - sub 0x80000000-1 -> 0x7FFFFFFF, ovf=1.
  - beq (alu_op=01) with a=b=0x1234 -> zero=1, ovf=0.
- Branch target:
  - pc_plus4=0x00000010, imm_ext=0xFFFFFFFE -> 0x00000008.
  - imm_ext=3 -> 0x0000001C.
  - pc_plus4=0xFFFFFFFC, imm_ext=1 -> 0x00000000 (wrap).
- Illegal and hold:
  - alu_op=10, funct=000000 -> alu_ctrl=1111, result=0, zero=1, illegal=1.
  - Next cycle in_valid=0 with changed inputs -> data outputs unchanged, out_valid=0.

Source files
------------

// File: rtl/mips_exec_alu_pkg.sv
// mips_alu_pkg: shared constants for the MIPS execute-stage ALU.
//   - ALU operation codes driven into the ALU core
//   - ALUOp encodings produced by the main control unit
//   - R-type funct field encodings understood by the ALU-control decode
package mips_alu_pkg;

  // ALU operation codes (4 bits wide, matches CTRL_W default)
  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SLT     = 4'b0111;
  localparam logic [3:0] ALU_NOR     = 4'b1100;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  // ALUOp from main control
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,  // lw / sw address calculation
    ALUOP_SUB   = 2'b01,  // beq comparison
    ALUOP_RTYPE = 2'b10,  // decode the funct field
    ALUOP_OR    = 2'b11   // ori
  } aluop_e;

  // R-type funct encodings
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;

endpackage

// File: rtl/mips_exec_alu_if.sv
// mips_exec_alu_if: operand/control inputs and registered results of the
// execute-stage ALU block.
//   master : producer of operands, consumer of results (decode stage / bench)
//   slave  : the mips_exec_alu block itself
interface mips_exec_alu_if #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
);
  logic              in_valid;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic [1:0]        alu_op;
  logic [5:0]        funct;
  logic [WIDTH-1:0]  pc_plus4;
  logic [WIDTH-1:0]  imm_ext;

  logic              out_valid;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [WIDTH-1:0]  result;
  logic              zero;
  logic              ovf;
  logic [WIDTH-1:0]  branch_target;
  logic              illegal;

  modport master (
    output in_valid, a, b, alu_op, funct, pc_plus4, imm_ext,
    input  out_valid, alu_ctrl, result, zero, ovf, branch_target, illegal
  );

  modport slave (
    input  in_valid, a, b, alu_op, funct, pc_plus4, imm_ext,
    output out_valid, alu_ctrl, result, zero, ovf, branch_target, illegal
  );
endinterface

// File: rtl/mips_alu_core.sv
// mips_alu_core: combinational 32-bit MIPS ALU.
//   a, b    : operands
//   ctrl    : ALU operation code (mips_alu_pkg ALU_*)
//   no_ovf  : suppress the overflow flag (addu / subu)
//   result  : operation result; 0 for unsupported codes
//   zero    : result == 0
//   ovf     : signed overflow of add / sub
module mips_alu_core
  import mips_alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic              no_ovf,
  output logic [WIDTH-1:0]  result,
  output logic              zero,
  output logic              ovf
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             add_ovf;
  logic             sub_ovf;

  assign sum  = a + b;
  assign diff = a - b;

  // Signed overflow from sign bits only: same-sign inputs to add, or
  // different-sign inputs to sub, that flip the sign of the result.
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (ctrl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: begin
        result = sum;
        ovf    = add_ovf && !no_ovf;
      end
      ALU_SUB: begin
        result = diff;
        ovf    = sub_ovf && !no_ovf;
      end
      // The true signed less-than is the sign of a-b corrected by overflow.
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
      ALU_NOR: result = ~(a | b);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mips_exec_alu.sv
// mips_exec_alu: registered MIPS execute-stage arithmetic block.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : mips_exec_alu_if.slave
//     inputs  in_valid, a, b, alu_op, funct, pc_plus4, imm_ext
//     outputs out_valid, alu_ctrl, result, zero, ovf, branch_target, illegal
// ALU-control decode and the branch-target adder are combinational; all
// outputs come from one register that loads on in_valid (one-cycle latency).
module mips_exec_alu
  import mips_alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mips_exec_alu_if.slave bus
);

  // ALU-control decode
  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_no_ovf;
  logic              dec_illegal;

  always_comb begin
    dec_ctrl    = ALU_ILLEGAL;
    dec_no_ovf  = 1'b0;
    dec_illegal = 1'b0;
    case (aluop_e'(bus.alu_op))
      ALUOP_ADD: dec_ctrl = ALU_ADD;
      ALUOP_SUB: dec_ctrl = ALU_SUB;
      ALUOP_OR:  dec_ctrl = ALU_OR;
      ALUOP_RTYPE: begin
        case (bus.funct)
          FUNCT_ADD:  dec_ctrl = ALU_ADD;
          FUNCT_SUB:  dec_ctrl = ALU_SUB;
          FUNCT_AND:  dec_ctrl = ALU_AND;
          FUNCT_OR:   dec_ctrl = ALU_OR;
          FUNCT_SLT:  dec_ctrl = ALU_SLT;
          FUNCT_NOR:  dec_ctrl = ALU_NOR;
          FUNCT_ADDU: begin
            dec_ctrl   = ALU_ADD;
            dec_no_ovf = 1'b1;
          end
          FUNCT_SUBU: begin
            dec_ctrl   = ALU_SUB;
            dec_no_ovf = 1'b1;
          end
          default: begin
            dec_ctrl    = ALU_ILLEGAL;
            dec_illegal = 1'b1;
          end
        endcase
      end
      default: dec_ctrl = ALU_ILLEGAL;
    endcase
  end

  // Main ALU
  logic [WIDTH-1:0] core_result;
  logic             core_zero;
  logic             core_ovf;

  mips_alu_core #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) u_core (
    .a      (bus.a),
    .b      (bus.b),
    .ctrl   (dec_ctrl),
    .no_ovf (dec_no_ovf),
    .result (core_result),
    .zero   (core_zero),
    .ovf    (core_ovf)
  );

  // Branch-target adder: word offset becomes a byte offset; wraps silently.
  logic [WIDTH-1:0] target_sum;
  assign target_sum = bus.pc_plus4 + {bus.imm_ext[WIDTH-3:0], 2'b00};

  // Output register
  logic              out_valid_d, out_valid_q;
  logic [CTRL_W-1:0] alu_ctrl_d, alu_ctrl_q;
  logic [WIDTH-1:0]  result_d, result_q;
  logic              zero_d, zero_q;
  logic              ovf_d, ovf_q;
  logic [WIDTH-1:0]  branch_target_d, branch_target_q;
  logic              illegal_d, illegal_q;

  // Data fields hold while in_valid is low; only out_valid follows it.
  always_comb begin
    out_valid_d     = bus.in_valid;
    alu_ctrl_d      = alu_ctrl_q;
    result_d        = result_q;
    zero_d          = zero_q;
    ovf_d           = ovf_q;
    branch_target_d = branch_target_q;
    illegal_d       = illegal_q;
    if (bus.in_valid) begin
      alu_ctrl_d      = dec_ctrl;
      result_d        = core_result;
      zero_d          = core_zero;
      ovf_d           = core_ovf;
      branch_target_d = target_sum;
      illegal_d       = dec_illegal;
    end
  end

  // NOTE: flops use non-blocking assignments so every register samples the
  // pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q     <= 1'b0;
      alu_ctrl_q      <= '0;
      result_q        <= '0;
      zero_q          <= 1'b0;
      ovf_q           <= 1'b0;
      branch_target_q <= '0;
      illegal_q       <= 1'b0;
    end else begin
      out_valid_q     <= out_valid_d;
      alu_ctrl_q      <= alu_ctrl_d;
      result_q        <= result_d;
      zero_q          <= zero_d;
      ovf_q           <= ovf_d;
      branch_target_q <= branch_target_d;
      illegal_q       <= illegal_d;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.alu_ctrl      = alu_ctrl_q;
  assign bus.result        = result_q;
  assign bus.zero          = zero_q;
  assign bus.ovf           = ovf_q;
  assign bus.branch_target = branch_target_q;
  assign bus.illegal       = illegal_q;

endmodule

// File: tb/tb_mips_exec_alu.sv
// tb_mips_exec_alu: self-checking bench for mips_exec_alu.
// Directed vector table, reset/hold sequences, then random stimulus checked
// against an arithmetic reference model.
module tb_mips_exec_alu;

  logic clk;
  logic rst_n;

  mips_exec_alu_if #(.WIDTH(32), .CTRL_W(4)) bus ();

  mips_exec_alu #(.WIDTH(32), .CTRL_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] imm;
  } in_t;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic        illegal;
    logic [31:0] bt;
  } exp_t;

  typedef struct {
    string name;
    in_t   i;
    exp_t  e;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic exp_valid, input exp_t e);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(exp_valid));
    check({tag, ".alu_ctrl"},  32'(bus.alu_ctrl),  32'(e.ctrl));
    check({tag, ".result"},    bus.result,         e.result);
    check({tag, ".zero"},      32'(bus.zero),      32'(e.zero));
    check({tag, ".ovf"},       32'(bus.ovf),       32'(e.ovf));
    check({tag, ".illegal"},   32'(bus.illegal),   32'(e.illegal));
    check({tag, ".branch"},    bus.branch_target,  e.bt);
  endtask

  // Reference model: MIPS semantics in plain integer arithmetic.
  function automatic exp_t model(input in_t i);
    exp_t   e;
    longint sa = longint'($signed(i.a));
    longint sb = longint'($signed(i.b));
    longint wide;
    e.illegal = 1'b0;
    e.ovf     = 1'b0;
    e.ctrl    = 4'hF;
    e.result  = 32'd0;
    case (i.alu_op)
      2'b00: begin e.ctrl = 4'h2; e.result = i.a + i.b; wide = sa + sb;
                   e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
      2'b01: begin e.ctrl = 4'h6; e.result = i.a - i.b; wide = sa - sb;
                   e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
      2'b11: begin e.ctrl = 4'h1; e.result = i.a | i.b; end
      default: begin
        case (i.funct)
          6'h20: begin e.ctrl = 4'h2; e.result = i.a + i.b; wide = sa + sb;
                       e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
          6'h22: begin e.ctrl = 4'h6; e.result = i.a - i.b; wide = sa - sb;
                       e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
          6'h21: begin e.ctrl = 4'h2; e.result = i.a + i.b; end
          6'h23: begin e.ctrl = 4'h6; e.result = i.a - i.b; end
          6'h24: begin e.ctrl = 4'h0; e.result = i.a & i.b; end
          6'h25: begin e.ctrl = 4'h1; e.result = i.a | i.b; end
          6'h27: begin e.ctrl = 4'hC; e.result = ~(i.a | i.b); end
          6'h2A: begin e.ctrl = 4'h7; e.result = (sa < sb) ? 32'd1 : 32'd0; end
          default: begin e.ctrl = 4'hF; e.result = 32'd0; e.illegal = 1'b1; end
        endcase
      end
    endcase
    e.zero = (e.result == 32'd0);
    e.bt   = i.pc + i.imm * 32'd4;
    return e;
  endfunction

  task automatic drive(input in_t i, input logic v);
    bus.in_valid = v;
    bus.alu_op   = i.alu_op;
    bus.funct    = i.funct;
    bus.a        = i.a;
    bus.b        = i.b;
    bus.pc_plus4 = i.pc;
    bus.imm_ext  = i.imm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input string n, input logic [1:0] op, input logic [5:0] f,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] pc, input logic [31:0] imm,
                              input logic [3:0] ctrl, input logic [31:0] res,
                              input logic z, input logic o, input logic ill,
                              input logic [31:0] bt);
    vec_t v;
    v.name = n;
    v.i = '{alu_op: op, funct: f, a: a, b: b, pc: pc, imm: imm};
    v.e = '{ctrl: ctrl, result: res, zero: z, ovf: o, illegal: ill, bt: bt};
    return v;
  endfunction

  vec_t table_v[$];
  exp_t zero_exp;
  exp_t last_exp;
  in_t  cur;
  logic [5:0] functs [8];

  initial begin
    zero_exp = '{ctrl: 4'h0, result: 32'd0, zero: 1'b0, ovf: 1'b0, illegal: 1'b0, bt: 32'd0};
    functs = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A};

    //                  name        op     funct  a             b             pc            imm           ctrl  result        z     o     ill   bt
    table_v.push_back(mk("lw_add",  2'b00, 6'h00, 32'd5,        32'd7,        32'd0,        32'd0,        4'h2, 32'd12,       1'b0, 1'b0, 1'b0, 32'd0));
    table_v.push_back(mk("r_add",   2'b10, 6'h20, 32'h0000000F, 32'h000000F0, 32'd0,        32'd0,        4'h2, 32'h000000FF, 1'b0, 1'b0, 1'b0, 32'd0));
    table_v.push_back(mk("r_sub",   2'b10, 6'h22, 32'h0000000F, 32'h000000F0, 32'd0,        32'd0,        4'h6, 32'hFFFFFF1F, 1'b0, 1'b0, 1'b0, 32'd0));
    table_v.push_back(mk("r_and",   2'b10, 6'h24, 32'h0000000F, 32'h000000F0, 32'd0,        32'd0,        4'h0, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'd0));
    table_v.push_back(mk("r_or",    2'b10, 6'h25, 32'h0000000F, 32'h000000F0, 32'd0,        32'd0,        4'h1, 32'h000000FF, 1'b0, 1'b0, 1'b0, 32'd0));
    table_v.push_back(mk("r_nor",   2'b10, 6'h27, 32'h0000000F, 32'h000000F0, 32'd0,        32'd0,        4'hC, 32'hFFFFFF00, 1'b0, 1'b0, 1'b0, 32'd0));
    table_v.push_back(mk("r_slt",   2'b10, 6'h2A, 32'h0000000F, 32'h000000F0, 32'd0,        32'd0,        4'h7, 32'd1,        1'b0, 1'b0, 1'b0, 32'd0));
    table_v.push_back(mk("slt_neg", 2'b10, 6'h2A, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        4'h7, 32'd1,        1'b0, 1'b0, 1'b0, 32'd0));
    table_v.push_back(mk("slt_pos", 2'b10, 6'h2A, 32'd1,        32'hFFFFFFFF, 32'd0,        32'd0,        4'h7, 32'd0,        1'b1, 1'b0, 1'b0, 32'd0));
    table_v.push_back(mk("add_ovf", 2'b10, 6'h20, 32'h7FFFFFFF, 32'd1,        32'd0,        32'd0,        4'h2, 32'h80000000, 1'b0, 1'b1, 1'b0, 32'd0));
    table_v.push_back(mk("addu",    2'b10, 6'h21, 32'h7FFFFFFF, 32'd1,        32'd0,        32'd0,        4'h2, 32'h80000000, 1'b0, 1'b0, 1'b0, 32'd0));
    table_v.push_back(mk("sub_ovf", 2'b10, 6'h22, 32'h80000000, 32'd1,        32'd0,        32'd0,        4'h6, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 32'd0));
    table_v.push_back(mk("beq",     2'b01, 6'h2A, 32'h00001234, 32'h00001234, 32'd0,        32'd0,        4'h6, 32'd0,        1'b1, 1'b0, 1'b0, 32'd0));
    table_v.push_back(mk("ori",     2'b11, 6'h00, 32'h0000000F, 32'h000000F0, 32'd0,        32'd0,        4'h1, 32'h000000FF, 1'b0, 1'b0, 1'b0, 32'd0));
    table_v.push_back(mk("bt_neg",  2'b00, 6'h00, 32'd0,        32'd0,        32'h00000010, 32'hFFFFFFFE, 4'h2, 32'd0,        1'b1, 1'b0, 1'b0, 32'h00000008));
    table_v.push_back(mk("bt_pos",  2'b00, 6'h00, 32'd0,        32'd0,        32'h00000010, 32'd3,        4'h2, 32'd0,        1'b1, 1'b0, 1'b0, 32'h0000001C));
    table_v.push_back(mk("bt_wrap", 2'b00, 6'h00, 32'd0,        32'd0,        32'hFFFFFFFC, 32'd1,        4'h2, 32'd0,        1'b1, 1'b0, 1'b0, 32'h00000000));
    table_v.push_back(mk("illegal", 2'b10, 6'h00, 32'h0000000F, 32'h000000F0, 32'd0,        32'd0,        4'hF, 32'd0,        1'b1, 1'b0, 1'b1, 32'd0));

    // Reset state
    rst_n = 1'b0;
    drive(table_v[0].i, 1'b0);
    repeat (2) step();
    check_outputs("reset", 1'b0, zero_exp);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int k = 0; k < table_v.size(); k++) begin
      drive(table_v[k].i, 1'b1);
      step();
      check_outputs(table_v[k].name, 1'b1, table_v[k].e);
    end

    // Hold: in_valid low with different inputs keeps the illegal result
    last_exp = table_v[table_v.size()-1].e;
    cur = '{alu_op: 2'b00, funct: 6'h20, a: 32'd99, b: 32'd1, pc: 32'h100, imm: 32'd4};
    drive(cur, 1'b0);
    step();
    check_outputs("hold", 1'b0, last_exp);
    step();
    check_outputs("hold2", 1'b0, last_exp);

    // Async reset mid-operation discards captured values without a clock edge
    cur = '{alu_op: 2'b10, funct: 6'h25, a: 32'hA5A5A5A5, b: 32'h0F0F0F0F, pc: 32'h40, imm: 32'd2};
    drive(cur, 1'b1);
    step();
    check_outputs("pre_rst", 1'b1, model(cur));
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("mid_rst", 1'b0, zero_exp);
    @(negedge clk);
    rst_n = 1'b1;
    drive(cur, 1'b0);
    step();
    check_outputs("post_rst_idle", 1'b0, zero_exp);

    // Random stimulus against the model
    last_exp = zero_exp;
    for (int n = 0; n < 300; n++) begin
      logic v;
      cur.alu_op = 2'($urandom_range(0, 3));
      cur.funct  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : functs[$urandom_range(0, 7)];
      case ($urandom_range(0, 3))
        0:       begin cur.a = 32'h7FFFFFFF - 32'($urandom_range(0, 3)); cur.b = 32'($urandom_range(0, 5)); end
        1:       begin cur.a = 32'h80000000 + 32'($urandom_range(0, 3)); cur.b = 32'($urandom); end
        2:       begin cur.a = $urandom; cur.b = cur.a; end
        default: begin cur.a = $urandom; cur.b = $urandom; end
      endcase
      cur.pc  = $urandom & 32'hFFFFFFFC;
      cur.imm = 32'($signed(16'($urandom)));
      v = ($urandom_range(0, 4) != 0);
      drive(cur, v);
      step();
      if (v) last_exp = model(cur);
      check_outputs($sformatf("rand%0d", n), v, last_exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
